// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// State encoding, master indices and the owner write-mask gate.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    // A byte mask only reaches the memory for a live write request.
    function automatic logic [3:0] owner_wmask(input logic req, input logic we, input logic [3:0] wmask);
        return (req && we) ? wmask : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Round-robin winner selection between two requesters.
// Output is one-hot: bit 0 = CPU (M0), bit 1 = debug port (M1).
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    // On a tie the master that was not served last wins.
    always_comb begin
        win_o = 2'b00;
        if (req0_i && req1_i) begin
            win_o = (last_i == M_CPU) ? 2'b10 : 2'b01;
        end else if (req0_i) begin
            win_o = 2'b01;
        end else if (req1_i) begin
            win_o = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-RAM port between the CPU load/store unit and the debug loader.
// Round-robin ownership with bounded locked bursts and a registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4,
    parameter int unsigned AW       = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic          m0_lock_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [31:0]   m0_wdata_i,
    input  logic [3:0]    m0_wmask_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic          m1_lock_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [31:0]   m1_wdata_i,
    input  logic [3:0]    m1_wmask_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,

    output logic [31:0]   rdata_o,

    output logic [AW-1:0] dmem_raddr_o,
    output logic [AW-1:0] dmem_waddr_o,
    output logic [31:0]   dmem_wdata_o,
    output logic [3:0]    dmem_wmask_o,
    input  logic [31:0]   dmem_rdata_i
);

    localparam int unsigned   CW       = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic [1:0]    win;
    logic          gnt0, gnt1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;

    dmem_arb_rr_pick u_pick (
        .req0_i (m0_req_i),
        .req1_i (m1_req_i),
        .last_i (last_q),
        .win_o  (win)
    );

    // The owner drives the memory port; in IDLE everything is parked at zero.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        case (state_q)
            OWN0: begin
                gnt0      = m0_req_i;
                mem_addr  = m0_addr_i;
                mem_wdata = m0_wdata_i;
                mem_wmask = owner_wmask(m0_req_i, m0_we_i, m0_wmask_i);
            end
            OWN1: begin
                gnt1      = m1_req_i;
                mem_addr  = m1_addr_i;
                mem_wdata = m1_wdata_i;
                mem_wmask = owner_wmask(m1_req_i, m1_we_i, m1_wmask_i);
            end
            default: ;
        endcase
    end

    // A dropped request releases ownership regardless of lock.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (win[0]) begin
                    state_d = OWN0;
                end else if (win[1]) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0: begin
                if (m0_req_i && m0_lock_i && (cnt_q < CNT_LAST)) begin
                    state_d = OWN0;
                    cnt_d   = cnt_q + 1'b1;
                end else if (m1_req_i) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (m1_req_i && m1_lock_i && (cnt_q < CNT_LAST)) begin
                    state_d = OWN1;
                    cnt_d   = cnt_q + 1'b1;
                end else if (m0_req_i) begin
                    state_d = OWN0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = M_CPU;
        end else if (gnt1) begin
            last_d = M_DBG;
        end
        rvalid0_d = gnt0 && !m0_we_i;
        rvalid1_d = gnt1 && !m1_we_i;
        rdata_d   = (rvalid0_d || rvalid1_d) ? dmem_rdata_i : rdata_q;
    end

    // last resets to M1 so the CPU wins the first tie after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= M_DBG;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign m0_gnt_o     = gnt0;
    assign m1_gnt_o     = gnt1;
    assign m0_rvalid_o  = rvalid0_q;
    assign m1_rvalid_o  = rvalid1_q;
    assign rdata_o      = rdata_q;
    assign dmem_raddr_o = mem_addr;
    assign dmem_waddr_o = mem_addr;
    assign dmem_wdata_o = mem_wdata;
    assign dmem_wmask_o = mem_wmask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data RAM.
// Read data is predicted from a reference memory and matched through per-master queues.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int LOCK_MAX = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          m0Req, m0We, m0Lock, m1Req, m1We, m1Lock;
    logic [AW-1:0] m0Addr, m1Addr;
    logic [31:0]   m0Wdata, m1Wdata;
    logic [3:0]    m0Wmask, m1Wmask;
    logic          m0Gnt, m0Rvalid, m1Gnt, m1Rvalid;
    logic [31:0]   rdata;
    logic [AW-1:0] dmemRaddr, dmemWaddr;
    logic [31:0]   dmemWdata, dmemRdata;
    logic [3:0]    dmemWmask;

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [3:0]  expWmask;
        logic [1:0]  expGnt;
        logic [1:0]  expRvalid;
    } vec_t;

    vec_t        vecs [8];
    logic [1:0]  burstGnt [7];
    logic [31:0] ram [256];
    logic [31:0] refMem [256];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.LOCK_MAX(LOCK_MAX), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .m0_req_i     (m0Req),
        .m0_we_i      (m0We),
        .m0_lock_i    (m0Lock),
        .m0_addr_i    (m0Addr),
        .m0_wdata_i   (m0Wdata),
        .m0_wmask_i   (m0Wmask),
        .m0_gnt_o     (m0Gnt),
        .m0_rvalid_o  (m0Rvalid),
        .m1_req_i     (m1Req),
        .m1_we_i      (m1We),
        .m1_lock_i    (m1Lock),
        .m1_addr_i    (m1Addr),
        .m1_wdata_i   (m1Wdata),
        .m1_wmask_i   (m1Wmask),
        .m1_gnt_o     (m1Gnt),
        .m1_rvalid_o  (m1Rvalid),
        .rdata_o      (rdata),
        .dmem_raddr_o (dmemRaddr),
        .dmem_waddr_o (dmemWaddr),
        .dmem_wdata_o (dmemWdata),
        .dmem_wmask_o (dmemWmask),
        .dmem_rdata_i (dmemRdata)
    );

    function automatic logic [31:0] initWord(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 2) return 32'h11223344;
        return {8'hA5, b, ~b, 8'h5A};
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural RAM: combinational read, byte-masked write; reloads its image while in reset.
    assign dmemRdata = ram[dmemRaddr[9:2]];
    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 256; i++) ram[i] <= initWord(i);
        end else if (|dmemWmask) begin
            ram[dmemWaddr[9:2]] <= mergeWord(ram[dmemWaddr[9:2]], dmemWdata, dmemWmask);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkGnt(input string name, input logic [1:0] expected);
        checkOutput(name, {30'b0, m1Gnt, m0Gnt}, {30'b0, expected});
    endtask

    task automatic checkRvalid(input string name, input logic [1:0] expected);
        checkOutput(name, {30'b0, m1Rvalid, m0Rvalid}, {30'b0, expected});
    endtask

    task automatic applyStimulus(input logic m, input logic req, input logic we, input logic lock,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
        if (!m) begin
            m0Req = req; m0We = we; m0Lock = lock; m0Addr = addr; m0Wdata = wdata; m0Wmask = wmask;
        end else begin
            m1Req = req; m1We = we; m1Lock = lock; m1Addr = addr; m1Wdata = wdata; m1Wmask = wmask;
        end
    endtask

    // Presents a transaction and records what the bench expects it to do.
    task automatic issue(input logic m, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
        applyStimulus(m, 1'b1, we, lock, addr, wdata, wmask);
        if (we) refMem[addr[9:2]] = mergeWord(refMem[addr[9:2]], wdata, wmask);
        else if (m) q1.push_back(refMem[addr[9:2]]);
        else q0.push_back(refMem[addr[9:2]]);
    endtask

    task automatic dropReq(input logic m);
        if (!m) begin m0Req = 1'b0; m0Lock = 1'b0; end
        else begin m1Req = 1'b0; m1Lock = 1'b0; end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearInputs();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Scoreboard side: every read return must match the oldest prediction for that master.
    always @(negedge clk) begin
        if (rstN) begin
            if (m0Rvalid) begin
                if (q0.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL m0UnexpectedRvalid: got rvalid 1, expected 0");
                end else begin
                    checkOutput("m0Rdata", rdata, q0.pop_front());
                end
            end
            if (m1Rvalid) begin
                if (q1.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL m1UnexpectedRvalid: got rvalid 1, expected 0");
                end else begin
                    checkOutput("m1Rdata", rdata, q1.pop_front());
                end
            end
            if (!m0Gnt && !m1Gnt) checkOutput("noGntWmask", {28'b0, dmemWmask}, 32'h0);
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h010, 32'h0,        4'hF, 4'h0, 2'b01, 2'b01};
        vecs[1] = '{1'b1, 1'b0, 32'h014, 32'h0,        4'h0, 4'h0, 2'b10, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 32'h020, 32'hDEADBEEF, 4'hF, 4'hF, 2'b01, 2'b00};
        vecs[3] = '{1'b0, 1'b0, 32'h020, 32'h0,        4'h0, 4'h0, 2'b01, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 32'h024, 32'h12345678, 4'h3, 4'h3, 2'b10, 2'b00};
        vecs[5] = '{1'b1, 1'b0, 32'h024, 32'h0,        4'h0, 4'h0, 2'b10, 2'b10};
        vecs[6] = '{1'b0, 1'b1, 32'h030, 32'hFFFFFFFF, 4'h0, 4'h0, 2'b01, 2'b00};
        vecs[7] = '{1'b0, 1'b0, 32'h034, 32'hFFFFFFFF, 4'hF, 4'h0, 2'b01, 2'b01};
        burstGnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};

        rstN = 1'b0;
        clearInputs();
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);

        // Outputs stay quiet in reset even with a pending request.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (3) midCycle();
        checkGnt("rstGnt", 2'b00);
        checkRvalid("rstRvalid", 2'b00);
        checkOutput("rstRdata", rdata, 32'h0);
        checkOutput("rstRaddr", dmemRaddr, 32'h0);
        checkOutput("rstWaddr", dmemWaddr, 32'h0);
        checkOutput("rstWdata", dmemWdata, 32'h0);
        checkOutput("rstWmask", {28'b0, dmemWmask}, 32'h0);

        nextCycle();
        rstN = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        midCycle(); checkGnt("firstC0Gnt", 2'b00);
        nextCycle(); midCycle();
        checkGnt("firstC1Gnt", 2'b01);
        checkOutput("firstC1Raddr", dmemRaddr, 32'h100);
        nextCycle(); dropReq(1'b0);
        midCycle(); checkRvalid("firstC2Rvalid", 2'b01);
        checkOutput("firstRdataWord40", rdata, 32'hA5_40_BF_5A);
        nextCycle(); midCycle(); checkRvalid("firstC3Rvalid", 2'b00);

        for (int i = 0; i < 8; i++) begin
            nextCycle();
            issue(vecs[i].m, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            midCycle(); checkGnt($sformatf("vec%0dC0Gnt", i), 2'b00);
            nextCycle(); midCycle();
            checkGnt($sformatf("vec%0dC1Gnt", i), vecs[i].expGnt);
            checkOutput($sformatf("vec%0dRaddr", i), dmemRaddr, vecs[i].addr);
            checkOutput($sformatf("vec%0dWaddr", i), dmemWaddr, vecs[i].addr);
            checkOutput($sformatf("vec%0dWdata", i), dmemWdata, vecs[i].wdata);
            checkOutput($sformatf("vec%0dWmask", i), {28'b0, dmemWmask}, {28'b0, vecs[i].expWmask});
            nextCycle(); dropReq(vecs[i].m);
            midCycle(); checkRvalid($sformatf("vec%0dC2Rvalid", i), vecs[i].expRvalid);
        end

        // Partial-byte write by M1, read back by M0 against a fixed merged word.
        nextCycle();
        issue(1'b1, 1'b1, 1'b0, 32'h008, 32'hAABBCCDD, 4'b0101);
        midCycle(); nextCycle(); midCycle();
        checkGnt("maskC1Gnt", 2'b10);
        checkOutput("maskC1Wmask", {28'b0, dmemWmask}, 32'h5);
        nextCycle(); dropReq(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h008, 32'h0, 4'h0);
        q0.push_back(32'h11BB33DD);
        midCycle(); checkGnt("maskC2Gnt", 2'b00);
        nextCycle(); midCycle(); checkGnt("maskC3Gnt", 2'b01);
        nextCycle(); dropReq(1'b0);
        midCycle(); checkRvalid("maskC4Rvalid", 2'b01);

        // Tie after reset: M0 first, direct handover to M1, then M0 again.
        doReset();
        issue(1'b0, 1'b0, 1'b0, 32'h040, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 1'b0, 32'h044, 32'h0, 4'h0);
        midCycle(); checkGnt("tieC0Gnt", 2'b00);
        nextCycle(); midCycle(); checkGnt("tieC1Gnt", 2'b01);
        nextCycle(); issue(1'b0, 1'b0, 1'b0, 32'h048, 32'h0, 4'h0);
        midCycle(); checkGnt("tieC2Gnt", 2'b10); checkRvalid("tieC2Rvalid", 2'b01);
        nextCycle(); dropReq(1'b1);
        midCycle(); checkGnt("tieC3Gnt", 2'b01); checkRvalid("tieC3Rvalid", 2'b10);
        nextCycle(); dropReq(1'b0);
        midCycle(); checkGnt("tieC4Gnt", 2'b00); checkRvalid("tieC4Rvalid", 2'b01);

        // Locked burst of six M0 reads with M1 waiting: forced release after LOCK_MAX grants.
        doReset();
        issue(1'b0, 1'b0, 1'b1, 32'h080, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 1'b0, 32'h0C0, 32'h0, 4'h0);
        midCycle(); checkGnt("burstC0Gnt", 2'b00);
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            if (c >= 2 && c <= 5) issue(1'b0, 1'b0, 1'b1, 32'h080 + 32'(4 * (c - 1)), 32'h0, 4'h0);
            if (c == 6) dropReq(1'b1);
            if (c == 7) issue(1'b0, 1'b0, 1'b1, 32'h094, 32'h0, 4'h0);
            midCycle(); checkGnt($sformatf("burstC%0dGnt", c), burstGnt[c-1]);
        end
        nextCycle(); dropReq(1'b0);
        midCycle(); checkRvalid("burstC8Rvalid", 2'b01);

        // Request withdrawn while owning: no access, IDLE in the following cycle.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h060, 32'hCAFEF00D, 4'hF);
        midCycle(); checkGnt("dropC0Gnt", 2'b00);
        nextCycle(); m0Req = 1'b0;
        midCycle(); checkGnt("dropC1Gnt", 2'b00);
        checkOutput("dropC1Wmask", {28'b0, dmemWmask}, 32'h0);
        nextCycle(); issue(1'b0, 1'b0, 1'b0, 32'h060, 32'h0, 4'h0);
        midCycle(); checkGnt("dropC2Gnt", 2'b00);
        nextCycle(); midCycle(); checkGnt("dropC3Gnt", 2'b01);
        nextCycle(); dropReq(1'b0);
        midCycle(); checkRvalid("dropC4Rvalid", 2'b01);

        // Asynchronous reset in the middle of a locked burst.
        nextCycle(); issue(1'b0, 1'b0, 1'b1, 32'h0A0, 32'h0, 4'h0);
        midCycle();
        nextCycle(); midCycle(); checkGnt("arstC1Gnt", 2'b01);
        nextCycle(); issue(1'b0, 1'b0, 1'b1, 32'h0A4, 32'h0, 4'h0);
        midCycle(); checkGnt("arstC2Gnt", 2'b01); checkRvalid("arstC2Rvalid", 2'b01);
        #2; rstN = 1'b0; #1;
        checkGnt("arstGnt", 2'b00);
        checkRvalid("arstRvalid", 2'b00);
        checkOutput("arstRdata", rdata, 32'h0);
        checkOutput("arstRaddr", dmemRaddr, 32'h0);
        doReset();
        issue(1'b1, 1'b0, 1'b0, 32'h0B0, 32'h0, 4'h0);
        issue(1'b0, 1'b0, 1'b0, 32'h0A8, 32'h0, 4'h0);
        midCycle(); checkGnt("postC0Gnt", 2'b00);
        nextCycle(); midCycle(); checkGnt("postC1Gnt", 2'b01);
        nextCycle(); dropReq(1'b0);
        midCycle(); checkGnt("postC2Gnt", 2'b10);
        nextCycle(); dropReq(1'b1);
        midCycle(); checkGnt("postC3Gnt", 2'b00); checkRvalid("postC3Rvalid", 2'b10);

        repeat (2) nextCycle();
        checkOutput("q0Drained", 32'(q0.size()), 32'h0);
        checkOutput("q1Drained", 32'(q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
